// File: rtl/cache_line_store.sv
// Direct-mapped write-back cache storage: tag/valid/dirty/data arrays,
// RAM fill and writeback port, and single-level indirect address chaining.
module cache_line_store #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int INDEX_W = 3
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [1:0]        cacheIn,
   input  logic              dataInSel,
   input  logic              RAMreadEnable,
   input  logic              RAMwriteEnable,
   input  logic              indirect,
   input  logic [ADDR_W-1:0] addrIn,
   input  logic [DATA_W-1:0] cpuDataIn,
   input  logic [DATA_W-1:0] ramDataIn,
   output logic              isHit,
   output logic              isClean,
   output logic [DATA_W-1:0] dataOut,
   output logic [ADDR_W-1:0] ramAddr,
   output logic [DATA_W-1:0] ramDataOut,
   output logic              ramWe,
   output logic              ramRe
);

   localparam int TAG_W = ADDR_W - INDEX_W;
   localparam int LINES = 2 ** INDEX_W;
   localparam int PTR_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;

   localparam logic [1:0] CMD_CLR   = 2'b00;
   localparam logic [1:0] CMD_LATCH = 2'b01;
   localparam logic [1:0] CMD_READ  = 2'b10;
   localparam logic [1:0] CMD_WRITE = 2'b11;

   logic [ADDR_W-1:0] r_cur_addr;
   logic              r_chain;
   logic [DATA_W-1:0] r_data_out;
   logic [LINES-1:0]  r_valid;
   logic [LINES-1:0]  r_dirty;
   logic [DATA_W-1:0] r_data [LINES];
   logic [TAG_W-1:0]  r_tag  [LINES];

   logic [INDEX_W-1:0] w_idx;
   logic [TAG_W-1:0]   w_cur_tag;
   logic               w_hit;
   logic               w_wb;
   logic               w_fill;
   logic [PTR_W-1:0]   w_ptr_ext;
   logic [ADDR_W-1:0]  w_ptr;
   logic [DATA_W-1:0]  w_line_src;

   assign w_idx     = r_cur_addr[INDEX_W-1:0];
   assign w_cur_tag = r_cur_addr[ADDR_W-1:INDEX_W];
   assign w_hit     = r_valid[w_idx] && (r_tag[w_idx] == w_cur_tag);

   // Strobes are qualified by clr so an asserted reset drops them at once
   assign w_wb   = RAMwriteEnable && clr;
   assign w_fill = RAMreadEnable && !RAMwriteEnable && clr;

   assign w_ptr_ext  = PTR_W'(r_data_out);
   assign w_ptr      = w_ptr_ext[ADDR_W-1:0];
   assign w_line_src = dataInSel ? cpuDataIn : ramDataIn;

   assign isHit      = w_hit;
   assign isClean    = !(r_valid[w_idx] && r_dirty[w_idx]);
   assign dataOut    = r_data_out;
   assign ramWe      = w_wb;
   assign ramRe      = w_fill;
   assign ramAddr    = w_wb ? {r_tag[w_idx], w_idx} : r_cur_addr;
   assign ramDataOut = w_wb ? r_data[w_idx] : '0;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_cur_addr <= '0;
         r_chain    <= 1'b0;
         r_data_out <= '0;
         r_valid    <= '0;
         r_dirty    <= '0;
      end else begin
         unique case (cacheIn)
            CMD_CLR: begin
               r_cur_addr <= '0;
               r_chain    <= 1'b0;
               r_valid    <= '0;
               r_dirty    <= '0;
            end
            CMD_WRITE: begin
               r_valid[w_idx] <= 1'b1;
               r_dirty[w_idx] <= 1'b1;
            end
            default: begin
               if (cacheIn == CMD_LATCH) begin
                  if (r_chain) begin
                     r_cur_addr <= w_ptr;
                     r_chain    <= 1'b0;
                  end else begin
                     r_cur_addr <= addrIn;
                     r_chain    <= indirect;
                  end
               end else if (w_hit) begin
                  r_data_out <= r_data[w_idx];
               end
               if (w_wb) begin
                  r_dirty[w_idx] <= 1'b0;
               end else if (w_fill) begin
                  r_valid[w_idx] <= 1'b1;
                  r_dirty[w_idx] <= 1'b0;
               end
            end
         endcase
      end
   end

   // Line payload is not reset; valid bits make stale contents harmless
   always_ff @(posedge clk) begin
      if (clr) begin
         if (cacheIn == CMD_WRITE) begin
            r_data[w_idx] <= w_line_src;
            r_tag[w_idx]  <= w_cur_tag;
         end else if (cacheIn != CMD_CLR && w_fill) begin
            r_data[w_idx] <= ramDataIn;
            r_tag[w_idx]  <= w_cur_tag;
         end
      end
   end

endmodule

// File: tb/tb_cache_line_store.sv
// Directed self-checking bench for cache_line_store.
// Each scenario task drives vectors and checks hand-computed values.
module tb_cache_line_store;

   logic       clk;
   logic       clr;
   logic [1:0] cacheIn;
   logic       dataInSel;
   logic       RAMreadEnable;
   logic       RAMwriteEnable;
   logic       indirect;
   logic [7:0] addrIn;
   logic [7:0] cpuDataIn;
   logic [7:0] ramDataIn;
   logic       isHit;
   logic       isClean;
   logic [7:0] dataOut;
   logic [7:0] ramAddr;
   logic [7:0] ramDataOut;
   logic       ramWe;
   logic       ramRe;

   int checks = 0;
   int errors = 0;
   logic we_seen;

   cache_line_store #(.ADDR_W(8), .DATA_W(8), .INDEX_W(3)) dut (
      .clk(clk), .clr(clr), .cacheIn(cacheIn), .dataInSel(dataInSel),
      .RAMreadEnable(RAMreadEnable), .RAMwriteEnable(RAMwriteEnable),
      .indirect(indirect), .addrIn(addrIn), .cpuDataIn(cpuDataIn),
      .ramDataIn(ramDataIn), .isHit(isHit), .isClean(isClean),
      .dataOut(dataOut), .ramAddr(ramAddr), .ramDataOut(ramDataOut),
      .ramWe(ramWe), .ramRe(ramRe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(ramWe) if (ramWe === 1'b1) we_seen = 1'b1;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clr = 1'b0; cacheIn = 2'b10; dataInSel = 1'b0;
      RAMreadEnable = 1'b0; RAMwriteEnable = 1'b0; indirect = 1'b0;
      addrIn = 8'h00; cpuDataIn = 8'h00; ramDataIn = 8'h00;
      cyc(); cyc();
      checks++; if (isHit !== 1'b0) begin errors++; $display("FAIL rst_hit got=%b exp=0", isHit); end
      checks++; if (isClean !== 1'b1) begin errors++; $display("FAIL rst_clean got=%b exp=1", isClean); end
      checks++; if (dataOut !== 8'h00) begin errors++; $display("FAIL rst_dout got=%h exp=00", dataOut); end
      checks++; if (ramWe !== 1'b0 || ramRe !== 1'b0) begin errors++; $display("FAIL rst_strobes got=%b%b exp=00", ramWe, ramRe); end
      checks++; if (ramAddr !== 8'h00) begin errors++; $display("FAIL rst_raddr got=%h exp=00", ramAddr); end
      checks++; if (ramDataOut !== 8'h00) begin errors++; $display("FAIL rst_rdout got=%h exp=00", ramDataOut); end
      #2 clr = 1'b1;
      cyc();
   endtask

   task automatic test_fill();
      cacheIn = 2'b01; addrIn = 8'h2A; cyc();
      cacheIn = 2'b10;
      checks++; if (isHit !== 1'b0 || isClean !== 1'b1) begin errors++; $display("FAIL fill_miss got hit=%b clean=%b exp hit=0 clean=1", isHit, isClean); end
      checks++; if (ramRe !== 1'b0) begin errors++; $display("FAIL fill_re_idle got=%b exp=0", ramRe); end
      RAMreadEnable = 1'b1; ramDataIn = 8'h5C; #1;
      checks++; if (ramRe !== 1'b1 || ramWe !== 1'b0) begin errors++; $display("FAIL fill_strobes got we=%b re=%b exp we=0 re=1", ramWe, ramRe); end
      checks++; if (ramAddr !== 8'h2A) begin errors++; $display("FAIL fill_raddr got=%h exp=2a", ramAddr); end
      cyc();
      RAMreadEnable = 1'b0; ramDataIn = 8'h00; #1;
      checks++; if (ramRe !== 1'b0) begin errors++; $display("FAIL fill_re_off got=%b exp=0", ramRe); end
      checks++; if (isHit !== 1'b1 || isClean !== 1'b1) begin errors++; $display("FAIL fill_hit got hit=%b clean=%b exp hit=1 clean=1", isHit, isClean); end
      checks++; if (dataOut !== 8'h00) begin errors++; $display("FAIL fill_dout_hold got=%h exp=00", dataOut); end
      cyc();
      checks++; if (dataOut !== 8'h5C) begin errors++; $display("FAIL fill_read got=%h exp=5c", dataOut); end
   endtask

   task automatic test_writeback();
      cacheIn = 2'b11; dataInSel = 1'b1; cpuDataIn = 8'h77; cyc();
      cacheIn = 2'b10;
      checks++; if (isHit !== 1'b1 || isClean !== 1'b0) begin errors++; $display("FAIL wb_dirty got hit=%b clean=%b exp hit=1 clean=0", isHit, isClean); end
      cacheIn = 2'b01; addrIn = 8'h32; cyc();
      cacheIn = 2'b10;
      checks++; if (isHit !== 1'b0 || isClean !== 1'b0) begin errors++; $display("FAIL wb_victim got hit=%b clean=%b exp hit=0 clean=0", isHit, isClean); end
      RAMwriteEnable = 1'b1; #1;
      checks++; if (ramAddr !== 8'h2A) begin errors++; $display("FAIL wb_raddr got=%h exp=2a", ramAddr); end
      checks++; if (ramDataOut !== 8'h77) begin errors++; $display("FAIL wb_rdout got=%h exp=77", ramDataOut); end
      checks++; if (ramWe !== 1'b1 || ramRe !== 1'b0) begin errors++; $display("FAIL wb_strobes got we=%b re=%b exp we=1 re=0", ramWe, ramRe); end
      cyc();
      RAMwriteEnable = 1'b0; #1;
      checks++; if (isClean !== 1'b1) begin errors++; $display("FAIL wb_clean got=%b exp=1", isClean); end
      checks++; if (ramWe !== 1'b0 || ramAddr !== 8'h32) begin errors++; $display("FAIL wb_idle got we=%b addr=%h exp we=0 addr=32", ramWe, ramAddr); end
   endtask

   task automatic test_clear();
      we_seen = 1'b0;
      cacheIn = 2'b01; addrIn = 8'h2A; cyc();
      cacheIn = 2'b11; dataInSel = 1'b1; cpuDataIn = 8'h11; cyc();
      cacheIn = 2'b10;
      checks++; if (isClean !== 1'b0) begin errors++; $display("FAIL clr_dirty got=%b exp=0", isClean); end
      cacheIn = 2'b00; cyc();
      checks++; if (ramAddr !== 8'h00) begin errors++; $display("FAIL clr_addr got=%h exp=00", ramAddr); end
      cacheIn = 2'b01; addrIn = 8'h2A; cyc();
      cacheIn = 2'b10;
      checks++; if (isHit !== 1'b0 || isClean !== 1'b1) begin errors++; $display("FAIL clr_miss got hit=%b clean=%b exp hit=0 clean=1", isHit, isClean); end
      checks++; if (we_seen !== 1'b0) begin errors++; $display("FAIL clr_no_we got=%b exp=0", we_seen); end
   endtask

   task automatic test_indirect();
      cacheIn = 2'b01; addrIn = 8'h10; indirect = 1'b0; cyc();
      cacheIn = 2'b11; dataInSel = 1'b0; ramDataIn = 8'h2A; cyc();
      ramDataIn = 8'h00;
      cacheIn = 2'b01; addrIn = 8'h10; indirect = 1'b1; cyc();
      cacheIn = 2'b10; indirect = 1'b0; cyc();
      checks++; if (dataOut !== 8'h2A) begin errors++; $display("FAIL ind_ptr got=%h exp=2a", dataOut); end
      cacheIn = 2'b01; addrIn = 8'hFF; indirect = 1'b1; cyc();
      cacheIn = 2'b10; indirect = 1'b0;
      checks++; if (ramAddr !== 8'h2A) begin errors++; $display("FAIL ind_chain got=%h exp=2a", ramAddr); end
      cacheIn = 2'b01; addrIn = 8'h45; cyc();
      cacheIn = 2'b10;
      checks++; if (ramAddr !== 8'h45) begin errors++; $display("FAIL ind_unchain got=%h exp=45", ramAddr); end
   endtask

   task automatic test_both_enables();
      cacheIn = 2'b11; dataInSel = 1'b1; cpuDataIn = 8'h99; cyc();
      cacheIn = 2'b10; RAMreadEnable = 1'b1; RAMwriteEnable = 1'b1;
      ramDataIn = 8'hEE; #1;
      checks++; if (ramWe !== 1'b1 || ramRe !== 1'b0) begin errors++; $display("FAIL both_strobes got we=%b re=%b exp we=1 re=0", ramWe, ramRe); end
      checks++; if (ramAddr !== 8'h45 || ramDataOut !== 8'h99) begin errors++; $display("FAIL both_port got addr=%h data=%h exp addr=45 data=99", ramAddr, ramDataOut); end
      cyc();
      RAMreadEnable = 1'b0; RAMwriteEnable = 1'b0; ramDataIn = 8'h00; #1;
      checks++; if (isHit !== 1'b1 || isClean !== 1'b1) begin errors++; $display("FAIL both_state got hit=%b clean=%b exp hit=1 clean=1", isHit, isClean); end
      cyc();
      checks++; if (dataOut !== 8'h99) begin errors++; $display("FAIL both_data got=%h exp=99", dataOut); end
   endtask

   task automatic test_reset_mid_fill();
      cacheIn = 2'b01; addrIn = 8'h5B; cyc();
      cacheIn = 2'b10; RAMreadEnable = 1'b1; ramDataIn = 8'h33; #1;
      checks++; if (ramRe !== 1'b1) begin errors++; $display("FAIL mid_re_on got=%b exp=1", ramRe); end
      #1 clr = 1'b0; #1;
      checks++; if (ramRe !== 1'b0 || ramWe !== 1'b0) begin errors++; $display("FAIL mid_strobes got we=%b re=%b exp 00", ramWe, ramRe); end
      checks++; if (isHit !== 1'b0 || dataOut !== 8'h00) begin errors++; $display("FAIL mid_state got hit=%b dout=%h exp hit=0 dout=00", isHit, dataOut); end
      RAMreadEnable = 1'b0; ramDataIn = 8'h00;
      #1 clr = 1'b1;
      cycle_after_reset();
   endtask

   task automatic cycle_after_reset();
      cacheIn = 2'b01; addrIn = 8'h5B; cyc();
      cacheIn = 2'b10;
      checks++; if (isHit !== 1'b0 || isClean !== 1'b1) begin errors++; $display("FAIL mid_unfilled got hit=%b clean=%b exp hit=0 clean=1", isHit, isClean); end
   endtask

   initial begin
      we_seen = 1'b0;
      test_reset();
      test_fill();
      test_writeback();
      test_clear();
      test_indirect();
      test_both_enables();
      test_reset_mid_fill();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
